// File: rtl/counter_pkg.sv
// Shared types and next-count arithmetic for the two-phase N-bit counter.
// Operands are carried at the widest supported width and narrowed by the caller.
package counter_pkg;

   localparam int CNT_MAX_W = 16;

   typedef logic [CNT_MAX_W-1:0] cnt_t;

   // Load values beyond the count range saturate to the top count.
   function automatic cnt_t clamp_load(input cnt_t val, input int modulus);
      cnt_t top;
      top = CNT_MAX_W'(modulus - 1);
      return (val > top) ? top : val;
   endfunction

   function automatic cnt_t next_count(input cnt_t q, input logic up, input logic en,
                                       input logic load, input cnt_t load_val,
                                       input int modulus);
      cnt_t top;
      top = CNT_MAX_W'(modulus - 1);
      if (load)
         return clamp_load(load_val, modulus);
      else if (en && up)
         return (q == top) ? '0 : q + 1'b1;
      else if (en)
         return (q == '0) ? top : q - 1'b1;
      else
         return q;
   endfunction

endpackage

// File: rtl/counter_2ph_next.sv
// Combinational next-stage value and terminal-count decode for counter_2ph_n.
module counter_2ph_next
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2**WIDTH
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] next_val,
   output logic             tc
);

   localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

   cnt_t q_ext;
   cnt_t load_ext;
   cnt_t next_ext;

   assign q_ext    = CNT_MAX_W'(q);
   assign load_ext = CNT_MAX_W'(load_val);
   assign next_ext = next_count(q_ext, up, en, load, load_ext, MODULUS);
   assign next_val = WIDTH'(next_ext);

   assign tc = up ? (q == TOP_VAL) : (q == '0);

endmodule

// File: rtl/counter_2ph_n.sv
// N-bit two-phase counter: step_b computes stage from q, step_a commits stage to q.
// Define COUNTER_PHASE_ERR_EN to add the sticky phase_err strobe-overlap flag.
module counter_2ph_n
   import counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 2**WIDTH,
   parameter int RESET_VAL = 0
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             step_a,
   input  logic             step_b,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             carry
`ifdef COUNTER_PHASE_ERR_EN
  ,output logic             phase_err
`endif
);

   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] q_d, q_q;
   logic [WIDTH-1:0] stage_d, stage_q;
   logic             carry_pend_d, carry_pend_q;
   logic             carry_d, carry_q;
   logic [WIDTH-1:0] next_val;

   counter_2ph_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .q        (q_q),
      .up       (up),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .next_val (next_val),
      .tc       (tc)
   );

   // Each side reads only pre-edge register values, so overlapping strobes
   // never form a path from stage into q within one cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      q_d          = q_q;
      stage_d      = stage_q;
      carry_pend_d = carry_pend_q;
      carry_d      = carry_q;
      if (step_b) begin
         stage_d      = next_val;
         carry_pend_d = en & ~load & tc;
      end
      if (step_a) begin
         q_d     = stage_q;
         carry_d = carry_pend_q;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         q_q          <= RST_VAL;
         stage_q      <= RST_VAL;
         carry_pend_q <= 1'b0;
         carry_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         q_q          <= q_d;
         stage_q      <= stage_d;
         carry_pend_q <= carry_pend_d;
         carry_q      <= carry_d;
      end
   end

   assign q     = q_q;
   assign carry = carry_q;

`ifdef COUNTER_PHASE_ERR_EN
   logic b_pend_d, b_pend_q;
   logic phase_err_d, phase_err_q;

   // b_pend marks a computed stage that no step_a has committed yet.
   always_comb begin
      b_pend_d    = b_pend_q;
      phase_err_d = phase_err_q;
      if (step_b && (step_a || b_pend_q))
         phase_err_d = 1'b1;
      if (step_b)
         b_pend_d = 1'b1;
      else if (step_a)
         b_pend_d = 1'b0;
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         b_pend_q    <= 1'b0;
         phase_err_q <= 1'b0;
      end else begin
         b_pend_q    <= b_pend_d;
         phase_err_q <= phase_err_d;
      end
   end

   assign phase_err = phase_err_q;
`endif

endmodule

// File: tb/tb_counter_2ph_n.sv
// Directed-vector bench for counter_2ph_n at WIDTH=3, MODULUS=6, RESET_VAL=0.
// Define COUNTER_PHASE_ERR_EN for both bench and RTL to cover phase_err.
module tb_counter_2ph_n;

   localparam int WIDTH   = 3;
   localparam int MODULUS = 6;

   logic             sysclk;
   logic             rst_n;
   logic             step_a;
   logic             step_b;
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             carry;
`ifdef COUNTER_PHASE_ERR_EN
   logic             phase_err;
`endif

   int n_vec;
   int n_err;

   counter_2ph_n #(
      .WIDTH     (WIDTH),
      .MODULUS   (MODULUS),
      .RESET_VAL (0)
   ) dut (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .step_a   (step_a),
      .step_b   (step_b),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .tc       (tc),
      .carry    (carry)
`ifdef COUNTER_PHASE_ERR_EN
     ,.phase_err (phase_err)
`endif
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Strobes rise 1 time unit after an edge and are captured by the next edge.
   task automatic pulse_b();
      step_b = 1'b1;
      @(posedge sysclk); #1;
      step_b = 1'b0;
   endtask

   task automatic pulse_a();
      step_a = 1'b1;
      @(posedge sysclk); #1;
      step_a = 1'b0;
   endtask

   task automatic pulse_ab();
      step_a = 1'b1;
      step_b = 1'b1;
      @(posedge sysclk); #1;
      step_a = 1'b0;
      step_b = 1'b0;
   endtask

   task automatic pair();
      pulse_b();
      pulse_a();
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      step_a   = 1'b0;
      step_b   = 1'b0;
      en       = 1'b1;
      up       = 1'b1;
      load     = 1'b0;
      load_val = '0;

      #12;
      check("reset_q", 32'(q), 32'd0);
      check("reset_carry", 32'(carry), 32'd0);
      check("reset_tc_up", 32'(tc), 32'd0);
      up = 1'b0; #1;
      check("reset_tc_down", 32'(tc), 32'd1);
      up = 1'b1;
`ifdef COUNTER_PHASE_ERR_EN
      check("reset_phase_err", 32'(phase_err), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge sysclk); #1;

      // Up count through the wrap at MODULUS-1.
      for (int i = 1; i <= 5; i++) begin
         pair();
         check($sformatf("up_q_%0d", i), 32'(q), 32'(i));
         check($sformatf("up_carry_%0d", i), 32'(carry), 32'd0);
         check($sformatf("up_tc_%0d", i), 32'(tc), (i == 5) ? 32'd1 : 32'd0);
      end
      pair();
      check("wrap_q", 32'(q), 32'd0);
      check("wrap_carry", 32'(carry), 32'd1);
      pulse_b();
      check("wrap_carry_hold", 32'(carry), 32'd1);
      check("latency_q", 32'(q), 32'd0);
      pulse_a();
      check("post_wrap_q", 32'(q), 32'd1);
      check("post_wrap_carry", 32'(carry), 32'd0);

      // Load 0, then count down to borrow.
      load = 1'b1; load_val = 3'd0;
      pair();
      load = 1'b0;
      check("load0_q", 32'(q), 32'd0);
      up = 1'b0; #1;
      check("down_tc_at0", 32'(tc), 32'd1);
      pair();
      check("down_q", 32'(q), 32'd5);
      check("down_borrow", 32'(carry), 32'd1);

      // Load has priority over en; out-of-range values clamp.
      up = 1'b1; load = 1'b1; load_val = 3'd2;
      pulse_b();
      check("load_latency_q", 32'(q), 32'd5);
      pulse_a();
      check("load2_q", 32'(q), 32'd2);
      check("load2_carry", 32'(carry), 32'd0);
      load_val = 3'd7;
      pair();
      check("load7_clamp_q", 32'(q), 32'd5);
      load_val = 3'd2;
      pair();
      load = 1'b0;
      check("load2_again_q", 32'(q), 32'd2);

      // Idempotent repeated strobes at q = 2.
      for (int i = 0; i < 3; i++) begin
         pulse_a();
         check($sformatf("rep_a_%0d", i), 32'(q), 32'd2);
      end
      for (int i = 0; i < 3; i++) begin
         pulse_b();
         check($sformatf("rep_b_%0d", i), 32'(q), 32'd2);
      end
      pulse_a();
      check("rep_commit_q", 32'(q), 32'd3);
`ifdef COUNTER_PHASE_ERR_EN
      check("double_b_phase_err", 32'(phase_err), 32'd1);
`endif

      // Reset between step_b and step_a discards the pending stage.
      pair();
      check("pre_rst_q", 32'(q), 32'd4);
      pulse_b();
      rst_n = 1'b0;
      #1;
      check("mid_rst_q", 32'(q), 32'd0);
      check("mid_rst_carry", 32'(carry), 32'd0);
`ifdef COUNTER_PHASE_ERR_EN
      check("mid_rst_phase_err", 32'(phase_err), 32'd0);
`endif
      #1;
      rst_n = 1'b1;
      pulse_a();
      check("after_rst_a_q", 32'(q), 32'd0);

      // Overlapping strobes: q takes old stage, stage comes from old q.
      pair();
      check("ov_pre_q", 32'(q), 32'd1);
      pulse_b();
      pulse_ab();
      check("ov1_q", 32'(q), 32'd2);
      pulse_ab();
      check("ov2_q", 32'(q), 32'd2);
      pulse_a();
      check("ov_commit_q", 32'(q), 32'd3);
`ifdef COUNTER_PHASE_ERR_EN
      check("overlap_phase_err", 32'(phase_err), 32'd1);
      pair();
      check("phase_err_sticky", 32'(phase_err), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/counter_2ph_n.md
Name: counter_2ph_n

Overview:
- Parametrised N-bit two-phase counter: the next generation of the single-bit two-phase counter cell.
- Stage register is computed on step_b and committed to the visible output on step_a, giving master/slave behaviour under the single sysclk.
- Adds up/down counting, synchronous load, programmable modulus, terminal count and a cascadable carry.
- Used for the timing-cycle counter (modulus 8), the DCL/SRC bank counters and chained program-address counting.

Parameters:
- WIDTH, 4: counter width in bits (1..16).
- MODULUS, 2**WIDTH: count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
- RESET_VAL, 0: value of q and stage after reset; must be < MODULUS.

Ports:
- sysclk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- step_a  input  1  phase-A strobe: commit stage -> q.
- step_b  input  1  phase-B strobe: compute stage from q.
- en  input  1  count enable, sampled on step_b.
- up  input  1  direction, sampled on step_b: 1 = up, 0 = down.
- load  input  1  synchronous load, sampled on step_b; takes priority over en.
- load_val  input  WIDTH  load value.
- q  output  WIDTH  visible count (registered).
- tc  output  1  terminal count (combinational from q and up).
- carry  output  1  registered carry/borrow for cascading.
- phase_err  output  1  present only with COUNTER_PHASE_ERR_EN.

Behaviour:
- Reset (async, rst_n low): q = RESET_VAL, stage = RESET_VAL, carry = 0, carry_pend = 0. Release is synchronous to sysclk; no step is lost or duplicated after release.
- On sysclk with step_b:
  - if load: stage <= min(load_val, MODULUS-1).
  - else if en and up: stage <= (q == MODULUS-1) ? 0 : q+1.
  - else if en and !up: stage <= (q == 0) ? MODULUS-1 : q-1.
  - else: stage <= q.
  - carry_pend <= en & !load & tc.
- On sysclk with step_a: q <= stage; carry <= carry_pend.
- Both strobes in the same cycle: each side uses pre-edge values (q gets the old stage, stage is computed from the old q). No combinational path from stage to q.
- Repeated step_a with no intervening step_b: q is unchanged (idempotent); the count advances at most once per B->A pair.
- Repeated step_b with no step_a: stage is recomputed from the unchanged q; no double count.
- tc = up ? (q == MODULUS-1) : (q == 0).
- carry is high for exactly one A-to-A interval, after the wrap commits: q goes from MODULUS-1 to 0 (up) or from 0 to MODULUS-1 (down). Feed it to the next stage's en.
- Latency: q reflects load or en one step_a after the sampling step_b.
- Arithmetic is modulo MODULUS; q never leaves 0..MODULUS-1.
- Reset asserted mid-pair (after step_b, before step_a): the pending stage is discarded.

Optional Feature:
- Macro: COUNTER_PHASE_ERR_EN.
- With the macro defined:
  - The phase_err port exists.
  - phase_err is a sticky flag set on any sysclk edge where step_a and step_b are both high, or where step_b occurs twice with no step_a between.
  - It clears only on reset.
- Without the macro: the port and its logic are absent; overlapping strobes behave as described in Behaviour.

Decomposition:
- Package counter_pkg: function next_count(q, up, en, load, load_val, MODULUS) and the clamp rule for load_val.
- One natural sub-module, counter_2ph_next: combinational next-value and tc logic.
- The top level holds the q, stage, carry_pend and carry registers, plus the phase-error logic.

Test Plan:
- WIDTH=3, MODULUS=6, up=1, en=1, five B/A pairs from reset -> q = 1,2,3,4,5; a sixth pair gives q = 0 and carry high for one A-interval; tc is high while q = 5.
- Down count from 0, MODULUS=6 -> q = 5 after the first pair, with carry (borrow) asserted.
- load=1, load_val=7, MODULUS=6 -> q = 5 after the next step_a; load with en=1 -> load wins.
- Three step_a pulses with no step_b, then three step_b pulses with no step_a, at q = 2 -> q stays 2 throughout; the next step_a gives q = 3.
- rst_n pulsed low between step_b and step_a at q = 4 -> q = RESET_VAL immediately; the following step_a keeps RESET_VAL.
- With COUNTER_PHASE_ERR_EN: step_a and step_b high in the same cycle -> phase_err = 1 and stays 1 until rst_n goes low.
